// File: rtl/gyro_pkg.sv
// Shared types and default constants for the multi-channel gyro integrator.
package gyro_pkg;

  // Scale/wrap sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCALE   = 2'd1,
    WRAP    = 2'd2,
    PUBLISH = 2'd3
  } fsm_e;

  // Default configuration
  localparam int DEF_NUM_CH        = 3;
  localparam int DEF_RATE_W        = 16;
  localparam int DEF_ACC_W         = 43;
  localparam int DEF_WINDOW_CYCLES = 10_000_000;
  localparam int DEF_PRE_SHIFT     = 5;
  localparam int DEF_SCALE_MULT    = 43;
  localparam int DEF_SCALE_SHIFT   = 24;
  localparam int DEF_FRAC_BITS     = 8;
  localparam int DEF_ANGLE_MAX     = 360;

  // Channel indices
  localparam int CH_PITCH = 0;
  localparam int CH_ROLL  = 1;
  localparam int CH_YAW   = 2;

  // Larger of two integers, used for width derivation
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gyro_integrator_chk.sv
// Simulation-only checks for gyro_integrator.
module gyro_integrator_chk (
  input logic clk_100mhz,
  input logic rst_in,
  input logic zero,
  input logic win_end,
  input logic busy
);

  // A window must not close before the previous one has been published
  always @(posedge clk_100mhz) begin
    if (rst_in && !zero && win_end) begin
      assert (!busy) else $error("gyro_integrator: window ended while scale/wrap still busy");
    end
  end

endmodule

// File: rtl/rate_window_accum.sv
// Per-channel rate accumulator: bias removal, pre-shift, window accumulation
// and gapless snapshot/clear at the window boundary.
module rate_window_accum
  import gyro_pkg::*;
#(
  parameter int RATE_W    = DEF_RATE_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int PRE_SHIFT = DEF_PRE_SHIFT
) (
  input  logic                     clk_100mhz,
  input  logic                     rst_in,
  input  logic signed [RATE_W-1:0] rate,
  input  logic signed [RATE_W-1:0] bias,
  input  logic                     rate_valid,
  input  logic                     win_end,
  input  logic                     zero,
  output logic signed [ACC_W-1:0]  snap
);

  logic signed [RATE_W:0]  diff_s;
  logic signed [RATE_W:0]  shifted_s;
  logic signed [ACC_W-1:0] contrib_s;
  logic signed [ACC_W-1:0] acc_r;
  logic signed [ACC_W-1:0] snap_r;

  // This cycle's bias-corrected, pre-shifted contribution (one extra bit so the subtraction never overflows)
  always_comb begin
    diff_s    = $signed({rate[RATE_W-1], rate}) - $signed({bias[RATE_W-1], bias});
    shifted_s = diff_s >>> PRE_SHIFT;
    if (rate_valid) begin
      contrib_s = ACC_W'(shifted_s);
    end else begin
      contrib_s = {ACC_W{1'b0}};
    end
  end

  // Accumulate; at window end fold in the current sample and restart from zero
  always_ff @(posedge clk_100mhz or negedge rst_in) begin
    if (!rst_in) begin
      acc_r  <= {ACC_W{1'b0}};
      snap_r <= {ACC_W{1'b0}};
    end else if (zero) begin
      acc_r  <= {ACC_W{1'b0}};
      snap_r <= {ACC_W{1'b0}};
    end else if (win_end) begin
      snap_r <= acc_r + contrib_s;
      acc_r  <= {ACC_W{1'b0}};
    end else begin
      acc_r  <= acc_r + contrib_s;
    end
  end

  assign snap = snap_r;

endmodule

// File: rtl/gyro_integrator.sv
// Multi-channel gyro integrator: windowed rate accumulation, shared scaling
// multiplier, per-channel fixed-point angle with wrap into [0, ANGLE_MAX).
module gyro_integrator
  import gyro_pkg::*;
#(
  parameter int NUM_CH        = DEF_NUM_CH,
  parameter int RATE_W        = DEF_RATE_W,
  parameter int ACC_W         = DEF_ACC_W,
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int PRE_SHIFT     = DEF_PRE_SHIFT,
  parameter int SCALE_MULT    = DEF_SCALE_MULT,
  parameter int SCALE_SHIFT   = DEF_SCALE_SHIFT,
  parameter int FRAC_BITS     = DEF_FRAC_BITS,
  parameter int ANGLE_MAX     = DEF_ANGLE_MAX,
  parameter int ANG_W         = $clog2(ANGLE_MAX)
) (
  input  logic                       clk_100mhz,
  input  logic                       rst_in,
  input  logic [NUM_CH*RATE_W-1:0]   rate_in,
  input  logic                       rate_valid_in,
  input  logic [NUM_CH*RATE_W-1:0]   bias_in,
  input  logic                       zero_in,
  output logic [NUM_CH*ANG_W-1:0]    angle_out,
  output logic                       angle_valid_out,
  output logic                       busy_out
);

  localparam int CNT_W  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // Multiplier operand kept positive inside a signed product
  localparam int PROD_W = ACC_W + $clog2(SCALE_MULT + 1) + 1;
  localparam int MOD_W  = $clog2(ANGLE_MAX + 1) + FRAC_BITS + 1;
  // Room for an in-range angle plus the largest possible window delta
  localparam int ANGI_W = max_int(PROD_W - SCALE_SHIFT, MOD_W) + 2;

  localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [CH_W-1:0]          CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic signed [PROD_W-1:0] MULT_S   = PROD_W'(SCALE_MULT);
  localparam logic signed [ANGI_W-1:0] ANG_MOD  = ANGI_W'(ANGLE_MAX) << FRAC_BITS;

  logic [CNT_W-1:0]         cnt_r;
  logic                     win_end_s;
  fsm_e                     state_r;
  logic [CH_W-1:0]          ch_r;
  logic signed [ACC_W-1:0]  snap_s [NUM_CH];
  logic signed [ANGI_W-1:0] ang_r  [NUM_CH];
  logic signed [ACC_W-1:0]  snap_sel_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [PROD_W-1:0] delta_s;
  logic signed [ANGI_W-1:0] delta_ang_s;
  logic signed [ANGI_W-1:0] ang_cur_s;
  logic [NUM_CH*ANG_W-1:0]  angle_out_r;
  logic                     angle_valid_r;

  assign win_end_s = (cnt_r == CNT_LAST);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    rate_window_accum #(
      .RATE_W    (RATE_W),
      .ACC_W     (ACC_W),
      .PRE_SHIFT (PRE_SHIFT)
    ) u_accum (
      .clk_100mhz (clk_100mhz),
      .rst_in     (rst_in),
      .rate       (rate_in[k*RATE_W +: RATE_W]),
      .bias       (bias_in[k*RATE_W +: RATE_W]),
      .rate_valid (rate_valid_in),
      .win_end    (win_end_s),
      .zero       (zero_in),
      .snap       (snap_s[k])
    );
  end

  // Free-running window counter; a zero command restarts the window
  always_ff @(posedge clk_100mhz or negedge rst_in) begin
    if (!rst_in) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (zero_in || win_end_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Shared multiplier and shifter applied to the channel being scaled
  always_comb begin
    snap_sel_s  = snap_s[ch_r];
    ang_cur_s   = ang_r[ch_r];
    prod_s      = PROD_W'(snap_sel_s) * MULT_S;
    delta_s     = prod_s >>> SCALE_SHIFT;
    delta_ang_s = ANGI_W'(delta_s);
  end

  // Scale/wrap/publish sequencer owning the angle registers and outputs
  always_ff @(posedge clk_100mhz or negedge rst_in) begin
    if (!rst_in) begin
      state_r       <= IDLE;
      ch_r          <= {CH_W{1'b0}};
      angle_out_r   <= {(NUM_CH*ANG_W){1'b0}};
      angle_valid_r <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        ang_r[k] <= {ANGI_W{1'b0}};
      end
    end else if (zero_in) begin
      state_r       <= IDLE;
      ch_r          <= {CH_W{1'b0}};
      angle_out_r   <= {(NUM_CH*ANG_W){1'b0}};
      angle_valid_r <= 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        ang_r[k] <= {ANGI_W{1'b0}};
      end
    end else begin
      angle_valid_r <= 1'b0;
      if (win_end_s) begin
        // A fresh snapshot always restarts the sequence from channel 0
        state_r <= SCALE;
        ch_r    <= {CH_W{1'b0}};
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= IDLE;
          end
          SCALE: begin
            ang_r[ch_r] <= ang_cur_s + delta_ang_s;
            state_r     <= WRAP;
          end
          WRAP: begin
            if (ang_cur_s[ANGI_W-1]) begin
              ang_r[ch_r] <= ang_cur_s + ANG_MOD;
            end else if (ang_cur_s >= ANG_MOD) begin
              ang_r[ch_r] <= ang_cur_s - ANG_MOD;
            end else if (ch_r == CH_LAST) begin
              state_r <= PUBLISH;
            end else begin
              ch_r    <= ch_r + CH_W'(1);
              state_r <= SCALE;
            end
          end
          PUBLISH: begin
            for (int k = 0; k < NUM_CH; k++) begin
              angle_out_r[k*ANG_W +: ANG_W] <= ANG_W'(ang_r[k] >>> FRAC_BITS);
            end
            angle_valid_r <= 1'b1;
            state_r       <= IDLE;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

  assign angle_out       = angle_out_r;
  assign angle_valid_out = angle_valid_r;
  assign busy_out        = (state_r != IDLE);

  gyro_integrator_chk u_chk (
    .clk_100mhz (clk_100mhz),
    .rst_in     (rst_in),
    .zero       (zero_in),
    .win_end    (win_end_s),
    .busy       (busy_out)
  );

endmodule

// File: tb/tb_gyro_integrator.sv
// Directed testbench for gyro_integrator with a short window and unity scaling.
module tb_gyro_integrator;

  localparam int NUM_CH = 3;
  localparam int RATE_W = 16;
  localparam int ANG_W  = 9;
  localparam int WIN    = 16;

  logic                      clk_100mhz = 1'b0;
  logic                      rst_in;
  logic [NUM_CH*RATE_W-1:0]  rate_in;
  logic                      rate_valid_in;
  logic [NUM_CH*RATE_W-1:0]  bias_in;
  logic                      zero_in;
  logic [NUM_CH*ANG_W-1:0]   angle_out;
  logic                      angle_valid_out;
  logic                      busy_out;

  int checks  = 0;
  int errors  = 0;
  int edge_no = 0;
  int lat;
  bit busy_ok;

  gyro_integrator #(
    .NUM_CH        (NUM_CH),
    .RATE_W        (RATE_W),
    .ACC_W         (43),
    .WINDOW_CYCLES (WIN),
    .PRE_SHIFT     (0),
    .SCALE_MULT    (1),
    .SCALE_SHIFT   (0),
    .FRAC_BITS     (0),
    .ANGLE_MAX     (360),
    .ANG_W         (ANG_W)
  ) dut (
    .clk_100mhz      (clk_100mhz),
    .rst_in          (rst_in),
    .rate_in         (rate_in),
    .rate_valid_in   (rate_valid_in),
    .bias_in         (bias_in),
    .zero_in         (zero_in),
    .angle_out       (angle_out),
    .angle_valid_out (angle_valid_out),
    .busy_out        (busy_out)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ang(input int k);
    return {23'd0, angle_out[k*ANG_W +: ANG_W]};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_100mhz);
      #1;
      edge_no++;
    end
  endtask

  task automatic align();
    while (edge_no % WIN != 0) tick(1);
  endtask

  task automatic run_window(input logic signed [15:0] r0, input logic signed [15:0] r1,
                            input logic signed [15:0] r2, input bit alt);
    rate_in       = {r2, r1, r0};
    rate_valid_in = 1'b1;
    for (int i = 0; i < WIN; i++) begin
      tick(1);
      if (alt) rate_valid_in = ~rate_valid_in;
    end
    rate_in       = '0;
    rate_valid_in = 1'b1;
  endtask

  task automatic wait_valid(output int l, output bit b_ok);
    l    = 0;
    b_ok = 1'b1;
    do begin
      tick(1);
      l++;
      if (!angle_valid_out && !busy_out) b_ok = 1'b0;
    end while (!angle_valid_out && l < 40);
  endtask

  initial begin
    rst_in        = 1'b0;
    rate_in       = '0;
    rate_valid_in = 1'b1;
    bias_in       = '0;
    zero_in       = 1'b0;
    tick(3);
    check("reset_angle", {5'd0, angle_out}, 32'd0);
    check("reset_valid", {31'd0, angle_valid_out}, 32'd0);
    check("reset_busy", {31'd0, busy_out}, 32'd0);
    rst_in  = 1'b1;
    edge_no = 0;

    // ch0 = 2 for one window: 32, no wrap, latency 7
    run_window(16'sd2, 16'sd0, 16'sd0, 1'b0);
    check("t1_busy_at_window_end", {31'd0, busy_out}, 32'd1);
    wait_valid(lat, busy_ok);
    check("t1_latency", lat, 32'd7);
    check("t1_a0", ang(0), 32'd32);
    check("t1_a1", ang(1), 32'd0);
    check("t1_a2", ang(2), 32'd0);

    // ch1 = -3: -48 wraps once to 312
    align();
    run_window(16'sd0, -16'sd3, 16'sd0, 1'b0);
    wait_valid(lat, busy_ok);
    check("t2_latency", lat, 32'd8);
    check("t2_a1", ang(1), 32'd312);
    check("t2_a0", ang(0), 32'd32);

    // ch2 = 100: 1600 needs four corrections down to 160
    align();
    run_window(16'sd0, 16'sd0, 16'sd100, 1'b0);
    wait_valid(lat, busy_ok);
    check("t3_latency", lat, 32'd11);
    check("t3_busy_held", {31'd0, busy_ok}, 32'd1);
    check("t3_a2", ang(2), 32'd160);

    // Bias equal to rate over three windows leaves ch0 unchanged
    align();
    bias_in = {16'sd0, 16'sd0, 16'sd5};
    run_window(16'sd5, 16'sd0, 16'sd0, 1'b0);
    run_window(16'sd5, 16'sd0, 16'sd0, 1'b0);
    run_window(16'sd5, 16'sd0, 16'sd0, 1'b0);
    bias_in = '0;
    wait_valid(lat, busy_ok);
    check("t4_latency", lat, 32'd7);
    check("t4_a0", ang(0), 32'd32);

    // Alternate-cycle valid, rate 4: eight samples -> +32
    align();
    run_window(16'sd4, 16'sd0, 16'sd0, 1'b1);
    wait_valid(lat, busy_ok);
    check("t5_a0", ang(0), 32'd64);
    check("t5_a1", ang(1), 32'd312);

    // Zero mid-window: outputs clear next cycle, the zero-cycle sample is dropped
    align();
    rate_in = {16'sd0, 16'sd0, 16'sd7};
    tick(5);
    zero_in = 1'b1;
    rate_in = {16'sd0, 16'sd0, 16'sd2};
    tick(1);
    zero_in = 1'b0;
    edge_no = 0;
    check("t6_zero_valid", {31'd0, angle_valid_out}, 32'd1);
    check("t6_zero_a0", ang(0), 32'd0);
    check("t6_zero_a1", ang(1), 32'd0);
    check("t6_zero_a2", ang(2), 32'd0);
    run_window(16'sd2, 16'sd0, 16'sd0, 1'b0);
    wait_valid(lat, busy_ok);
    check("t6_latency", lat, 32'd7);
    check("t6_a0", ang(0), 32'd32);

    // Asynchronous reset in the middle of the ch2 wrap corrections
    align();
    run_window(16'sd0, 16'sd0, 16'sd100, 1'b0);
    tick(6);
    check("t7_busy_in_wrap", {31'd0, busy_out}, 32'd1);
    rst_in = 1'b0;
    #1;
    check("t7_rst_angle", {5'd0, angle_out}, 32'd0);
    check("t7_rst_valid", {31'd0, angle_valid_out}, 32'd0);
    check("t7_rst_busy", {31'd0, busy_out}, 32'd0);
    tick(2);
    rst_in  = 1'b1;
    edge_no = 0;
    run_window(16'sd0, -16'sd3, 16'sd0, 1'b0);
    wait_valid(lat, busy_ok);
    check("t8_latency", lat, 32'd8);
    check("t8_a0", ang(0), 32'd0);
    check("t8_a1", ang(1), 32'd312);
    check("t8_a2", ang(2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
